// File: rtl/scpu_wb_pkg.sv
// Shared write-back definitions for the scpu register-file path.
// Holds register-file geometry, requester indices and the contention helper.
package scpu_wb_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int MAX_REQ   = 8;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_CSR = 2;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic multi_hot(input logic [MAX_REQ-1:0] v);
        return (v & (v - {{(MAX_REQ-1){1'b0}}, 1'b1})) != '0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin priority search starting just after ptr.
// Latency: combinational. Backpressure: none, grant simply follows the request vector.
// One-hot grant plus encoded index; gnt_vld is low when nothing is requested.
module rr_arbiter #(
    parameter int N   = 3,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx,
    output logic           gnt_vld
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    always_comb begin
        int c;
        logic [IW-1:0] ci;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        c       = 0;
        ci      = '0;
        for (int k = 1; k <= N; k++) begin
            c  = (int'(ptr) + k) % N;
            ci = IW'(c);
            if (!gnt_vld && req[ci]) begin
                gnt_vld = 1'b1;
                gnt[ci] = 1'b1;
                gnt_idx = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Round-robin share of the register-file write port among N_REQ write-back requesters.
// Latency: one cycle from acceptance edge to rf_we; one write per cycle. Backpressure: req_ready one-hot grant.
// Optional REGS_WB_BYPASS_EN adds two combinational read-bypass ports off the rf_* write.
module regs_wb_arbiter
    import scpu_wb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDW   = 2,
    parameter int CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*RF_ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*RF_DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          rf_we,
    output logic [RF_ADDR_W-1:0]          rf_waddr,
    output logic [RF_DATA_W-1:0]          rf_wdata,
    output logic [IDW-1:0]                rf_wid,
`ifdef REGS_WB_BYPASS_EN
    input  logic [RF_ADDR_W-1:0]          byp_raddr_1,
    input  logic [RF_ADDR_W-1:0]          byp_raddr_2,
    input  logic [RF_DATA_W-1:0]          byp_rdata_in_1,
    input  logic [RF_DATA_W-1:0]          byp_rdata_in_2,
    output logic [RF_DATA_W-1:0]          byp_rdata_out_1,
    output logic [RF_DATA_W-1:0]          byp_rdata_out_2,
`endif
    output logic [CNT_W-1:0]              contention_cnt
);

    logic [IDW-1:0]   rr_ptr;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_vld;
    wb_req_t          sel;

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign req_ready = gnt & {N_REQ{rst_n}};

    // One-hot mux of the granted requester's address and data.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel.addr = req_addr[i*RF_ADDR_W +: RF_ADDR_W];
                sel.data = req_data[i*RF_DATA_W +: RF_DATA_W];
            end
        end
    end

    // A granted request is always accepted, so gnt_vld marks the handshake edge.
    // Writes to x0 complete the handshake but never assert rf_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_wid   <= '0;
            rr_ptr   <= IDW'(N_REQ - 1);
        end else if (gnt_vld) begin
            rf_we    <= (sel.addr != '0);
            rf_waddr <= sel.addr;
            rf_wdata <= sel.data;
            rf_wid   <= gnt_idx;
            rr_ptr   <= gnt_idx;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contention_cnt <= '0;
        end else if (multi_hot(MAX_REQ'(req_valid)) && (contention_cnt != '1)) begin
            contention_cnt <= contention_cnt + 1'b1;
        end
    end

`ifdef REGS_WB_BYPASS_EN
    assign byp_rdata_out_1 = (rf_we && (rf_waddr == byp_raddr_1) && (byp_raddr_1 != '0))
                             ? rf_wdata : byp_rdata_in_1;
    assign byp_rdata_out_2 = (rf_we && (rf_waddr == byp_raddr_2) && (byp_raddr_2 != '0))
                             ? rf_wdata : byp_rdata_in_2;
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Scoreboard bench for regs_wb_arbiter: expected writes queued at acceptance, checked one cycle later.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_regs_wb_arbiter;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  id;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  rf_wid;
    logic [15:0] contention_cnt;
`ifdef REGS_WB_BYPASS_EN
    logic [4:0]  byp_raddr_1, byp_raddr_2;
    logic [31:0] byp_rdata_in_1, byp_rdata_in_2;
    logic [31:0] byp_rdata_out_1, byp_rdata_out_2;
`endif

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;

    regs_wb_arbiter #(.N_REQ(3), .IDW(2), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .rf_wid         (rf_wid),
`ifdef REGS_WB_BYPASS_EN
        .byp_raddr_1    (byp_raddr_1),
        .byp_raddr_2    (byp_raddr_2),
        .byp_rdata_in_1 (byp_rdata_in_1),
        .byp_rdata_in_2 (byp_rdata_in_2),
        .byp_rdata_out_1(byp_rdata_out_1),
        .byp_rdata_out_2(byp_rdata_out_2),
`endif
        .contention_cnt (contention_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 3'b111;
        set_req(0, 5'd1, 32'h1);
        set_req(1, 5'd2, 32'h2);
        set_req(2, 5'd3, 32'h3);
        repeat (2) @(negedge clk);
        total++;
        if (req_ready !== 3'b000) begin
            bad++; $display("FAIL reset_ready got=%b exp=000", req_ready);
        end
        total++;
        if ({rf_we, rf_waddr, rf_wdata, rf_wid} !== 40'd0) begin
            bad++; $display("FAIL reset_rf got=%h exp=0", {rf_we, rf_waddr, rf_wdata, rf_wid});
        end
        total++;
        if (contention_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_cnt got=%0d exp=0", contention_cnt);
        end
        @(posedge clk); #1;
        req_valid = 3'b000;
        rst_n     = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [31:0] rr_data [3];
        exp_t it;
        int g;
        rr_data[0] = 32'hAAAA_000A;
        rr_data[1] = 32'hBBBB_000B;
        rr_data[2] = 32'hCCCC_000C;
        for (int i = 0; i < 3; i++) set_req(i, 5'(i + 1), rr_data[i]);
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            g = i % 3;
            total++;
            if (req_ready !== (3'b001 << g)) begin
                bad++; $display("FAIL rr_grant cycle=%0d got=%b exp_idx=%0d", i, req_ready, g);
            end
            total++;
            if (exp_q.size() == 0) begin
                if (rf_we !== 1'b0) begin
                    bad++; $display("FAIL rr_idle_we got=%b exp=0", rf_we);
                end
            end else begin
                it = exp_q.pop_front();
                if ({rf_we, rf_waddr, rf_wdata, rf_wid} !== it) begin
                    bad++; $display("FAIL rr_write got=%h exp=%h", {rf_we, rf_waddr, rf_wdata, rf_wid}, it);
                end
            end
            exp_q.push_back({1'b1, 5'(g + 1), rr_data[g], 2'(g)});
            exp_cnt++;
            @(posedge clk); #1;
        end
        req_valid = 3'b000;
        @(negedge clk);
        total++;
        it = exp_q.pop_front();
        if ({rf_we, rf_waddr, rf_wdata, rf_wid} !== it) begin
            bad++; $display("FAIL rr_last_write got=%h exp=%h", {rf_we, rf_waddr, rf_wdata, rf_wid}, it);
        end
        total++;
        if (contention_cnt !== 16'(exp_cnt)) begin
            bad++; $display("FAIL rr_cnt got=%0d exp=%0d", contention_cnt, exp_cnt);
        end
    endtask

    task automatic test_single();
        exp_t it;
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        @(negedge clk);
        total++;
        if (req_ready !== 3'b010) begin
            bad++; $display("FAIL single_ready got=%b exp=010", req_ready);
        end
        exp_q.push_back({1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1});
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(negedge clk);
        total++;
        it = exp_q.pop_front();
        if ({rf_we, rf_waddr, rf_wdata, rf_wid} !== it) begin
            bad++; $display("FAIL single_write got=%h exp=%h", {rf_we, rf_waddr, rf_wdata, rf_wid}, it);
        end
        @(negedge clk);
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL single_hold got=%b/%0d/%h exp=0/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_addr_zero();
        exp_t it;
        @(posedge clk); #1;
        set_req(0, 5'd0, 32'h0000_1234);
        req_valid = 3'b001;
        @(negedge clk);
        total++;
        if (req_ready !== 3'b001) begin
            bad++; $display("FAIL x0_ready got=%b exp=001", req_ready);
        end
        exp_q.push_back({1'b0, 5'd0, 32'h0000_1234, 2'd0});
        @(posedge clk); #1;
        set_req(0, 5'd6, 32'h66);
        set_req(1, 5'd4, 32'h44);
        req_valid = 3'b011;
        @(negedge clk);
        total++;
        if (req_ready !== 3'b010) begin
            bad++; $display("FAIL x0_ptr_advance got=%b exp=010", req_ready);
        end
        total++;
        it = exp_q.pop_front();
        if ({rf_we, rf_waddr, rf_wdata, rf_wid} !== it) begin
            bad++; $display("FAIL x0_no_write got=%h exp=%h", {rf_we, rf_waddr, rf_wdata, rf_wid}, it);
        end
        exp_q.push_back({1'b1, 5'd4, 32'h44, 2'd1});
        exp_cnt++;
        @(posedge clk); #1;
        req_valid = 3'b001;
        @(negedge clk);
        total++;
        it = exp_q.pop_front();
        if ({rf_we, rf_waddr, rf_wdata, rf_wid} !== it) begin
            bad++; $display("FAIL x0_req1_write got=%h exp=%h", {rf_we, rf_waddr, rf_wdata, rf_wid}, it);
        end
        exp_q.push_back({1'b1, 5'd6, 32'h66, 2'd0});
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(negedge clk);
        total++;
        it = exp_q.pop_front();
        if ({rf_we, rf_waddr, rf_wdata, rf_wid} !== it) begin
            bad++; $display("FAIL x0_req0_write got=%h exp=%h", {rf_we, rf_waddr, rf_wdata, rf_wid}, it);
        end
        total++;
        if (contention_cnt !== 16'(exp_cnt)) begin
            bad++; $display("FAIL x0_cnt got=%0d exp=%0d", contention_cnt, exp_cnt);
        end
    endtask

    task automatic test_same_addr();
        exp_t it;
        @(posedge clk); #1;
        set_req(2, 5'd8, 32'h99);
        req_valid = 3'b100;
        @(negedge clk);
        exp_q.push_back({1'b1, 5'd8, 32'h99, 2'd2});
        @(posedge clk); #1;
        set_req(0, 5'd7, 32'h11);
        set_req(2, 5'd7, 32'h22);
        req_valid = 3'b101;
        @(negedge clk);
        total++;
        if (req_ready !== 3'b001) begin
            bad++; $display("FAIL same_first_ready got=%b exp=001", req_ready);
        end
        it = exp_q.pop_front();
        exp_q.push_back({1'b1, 5'd7, 32'h11, 2'd0});
        exp_cnt++;
        @(posedge clk); #1;
        req_valid = 3'b100;
        @(negedge clk);
        total++;
        it = exp_q.pop_front();
        if ({rf_we, rf_waddr, rf_wdata, rf_wid} !== it) begin
            bad++; $display("FAIL same_first_write got=%h exp=%h", {rf_we, rf_waddr, rf_wdata, rf_wid}, it);
        end
        exp_q.push_back({1'b1, 5'd7, 32'h22, 2'd2});
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(negedge clk);
        total++;
        it = exp_q.pop_front();
        if ({rf_we, rf_waddr, rf_wdata, rf_wid} !== it) begin
            bad++; $display("FAIL same_second_write got=%h exp=%h", {rf_we, rf_waddr, rf_wdata, rf_wid}, it);
        end
        @(negedge clk);
        total++;
        if (rf_wdata !== 32'h22 || contention_cnt !== 16'(exp_cnt)) begin
            bad++; $display("FAIL same_final got=%h/%0d exp=22/%0d", rf_wdata, contention_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        set_req(1, 5'd3, 32'h77);
        req_valid = 3'b010;
        @(negedge clk);
        total++;
        if (req_ready !== 3'b010) begin
            bad++; $display("FAIL rstmid_ready got=%b exp=010", req_ready);
        end
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = 3'b000;
        #1;
        total++;
        if ({rf_we, contention_cnt, rf_wdata} !== 49'd0) begin
            bad++; $display("FAIL rstmid_clear got=%b/%0d/%h exp=0/0/0", rf_we, contention_cnt, rf_wdata);
        end
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 3'b111;
        @(negedge clk);
        total++;
        if (req_ready !== 3'b001) begin
            bad++; $display("FAIL rstmid_ptr got=%b exp=001", req_ready);
        end
        req_valid = 3'b000;
        @(negedge clk);
        total++;
        if (rf_we !== 1'b0 || contention_cnt !== 16'd0) begin
            bad++; $display("FAIL rstmid_nowrite got=%b/%0d exp=0/0", rf_we, contention_cnt);
        end
    endtask

`ifdef REGS_WB_BYPASS_EN
    task automatic test_bypass();
        @(posedge clk); #1;
        set_req(0, 5'd9, 32'h55);
        req_valid = 3'b001;
        @(posedge clk); #1;
        req_valid      = 3'b000;
        byp_raddr_1    = 5'd9;
        byp_rdata_in_1 = 32'h0;
        byp_raddr_2    = 5'd0;
        byp_rdata_in_2 = 32'h0000_ABCD;
        @(negedge clk);
        total++;
        if (byp_rdata_out_1 !== 32'h55) begin
            bad++; $display("FAIL byp_hit got=%h exp=55", byp_rdata_out_1);
        end
        total++;
        if (byp_rdata_out_2 !== 32'h0000_ABCD) begin
            bad++; $display("FAIL byp_x0 got=%h exp=abcd", byp_rdata_out_2);
        end
        byp_rdata_in_1 = 32'h1111;
        @(negedge clk);
        total++;
        if (byp_rdata_out_1 !== 32'h1111) begin
            bad++; $display("FAIL byp_idle got=%h exp=1111", byp_rdata_out_1);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = 3'b000;
        req_addr  = '0;
        req_data  = '0;
`ifdef REGS_WB_BYPASS_EN
        byp_raddr_1    = '0;
        byp_raddr_2    = '0;
        byp_rdata_in_1 = '0;
        byp_rdata_in_2 = '0;
`endif
        test_reset();
        test_round_robin();
        test_single();
        test_addr_zero();
        test_same_addr();
        test_reset_mid();
`ifdef REGS_WB_BYPASS_EN
        test_bypass();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the single register-file write port among N_REQ write-back requesters (default: ALU, load unit, CSR unit).
- Round-robin arbitration with a valid/ready handshake per requester.
- The granted write is registered, then driven to the register-file write port one cycle after acceptance.
- Sits between the execute/memory stages and the register file in the scpu datapath.

Parameters:
- N_REQ, 3, number of write-back requesters (2..8).
- IDW, 2, grant-id width; must satisfy 2^IDW >= N_REQ.
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  N_REQ*5  packed destination register addresses; requester i uses bits [5i+4:5i].
- req_data  in  N_REQ*32  packed write data; requester i uses bits [32i+31:32i].
- req_ready  out  N_REQ  one-hot grant; acceptance happens when valid and ready are both high.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- rf_wid  out  IDW  index of the requester whose write is on rf_*.
- contention_cnt  out  CNT_W  number of cycles in which two or more req_valid bits were high.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0, rf_wid=0.
  - rr_ptr=N_REQ-1, so requester 0 has first priority after reset.
  - contention_cnt=0.
  - req_ready is 0 while rst_n=0.
- Arbitration (combinational):
  - Search from (rr_ptr+1) mod N_REQ upward, wrapping; the first requester with req_valid high is the grantee g.
  - req_ready[g]=1; every other ready bit is 0.
  - If no requester is valid, req_ready=0.
  - req_ready may depend combinationally on req_valid; req_valid must never depend on req_ready.
- Acceptance, at the edge with req_valid[g] & req_ready[g]:
  - rf_waddr<=addr_g, rf_wdata<=data_g, rf_wid<=g, rr_ptr<=g.
  - rf_we<=1 if addr_g!=0.
  - If addr_g==0: rf_we<=0. The handshake still completes, and rr_ptr still advances.
- Latency: exactly 1 cycle from acceptance edge to rf_we high. One write per cycle at most, so throughput is 1 write/cycle.
- Idle cycle: rf_we<=0; rf_waddr, rf_wdata and rf_wid hold their values; rr_ptr holds.
- Requester obligation: once req_valid is high, addr and data stay stable and valid stays high until accepted.
- Fairness: with all N_REQ valid continuously, each requester is granted exactly once every N_REQ cycles.
- Same-address requests in one cycle: the write accepted later lands later and wins. No merging.
- contention_cnt increments when popcount(req_valid)>=2 and saturates at all-ones; it never wraps.
- Reset asserted mid-operation: a registered but unwritten write is discarded (rf_we drops immediately). Requesters re-present after reset.

Optional Feature:
- Macro: REGS_WB_BYPASS_EN.
- When defined, adds these ports:
  - byp_raddr_1/2 in 5.
  - byp_rdata_in_1/2 in 32 (register-file read data).
  - byp_rdata_out_1/2 out 32.
- Bypass rule: byp_rdata_out_k = rf_wdata when rf_we=1 and rf_waddr==byp_raddr_k and byp_raddr_k!=0; otherwise byp_rdata_in_k. Purely combinational, so readers see a write in the same cycle it hits the register file.
- When undefined: the ports are absent and no bypass logic exists.

Decomposition:
- Shared package scpu_wb_pkg holds:
  - RF_ADDR_W=5, RF_DATA_W=32.
  - The requester index constants WB_ALU=0, WB_LSU=1, WB_CSR=2.
  - A function computing popcount>=2.
- One sub-module, rr_arbiter: parameterised N-way round-robin priority search. Inputs are the request vector and rr_ptr; outputs are the one-hot grant and the encoded index.
- Registered output stage and counter stay in the top.

Test Plan:
- Reset, then req_valid=3'b111 held for 6 cycles with addrs 1/2/3 and data A/B/C:
  - grant order is 0,1,2,0,1,2;
  - rf_we rises 1 cycle after each acceptance with the matching addr/data;
  - contention_cnt=6.
- Single requester 1 with addr=5, data=0xDEADBEEF for 1 cycle: ready[1]=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rf_wid=1; cycle after, rf_we=0.
- Requester 0 with addr=0, data=0x1234: handshake completes, rf_we stays 0, and rr_ptr advances so requester 1 wins the next contended cycle.
- Requesters 0 and 2 both target addr 7 (data 0x11, 0x22) from rr_ptr=2: requester 0 is written first, then requester 2, and final rf_wdata=0x22.
- Drop rst_n mid-cycle right after an acceptance: rf_we=0 immediately, rr_ptr=N_REQ-1, contention_cnt=0, and no write occurs.
- With REGS_WB_BYPASS_EN: rf_we=1, rf_waddr=9, rf_wdata=0x55, byp_raddr_1=9, byp_rdata_in_1=0 → byp_rdata_out_1=0x55. With byp_raddr_2=0 → byp_rdata_out_2 = byp_rdata_in_2.
